// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving NUM_REQ processors exclusive access to a 2^ADDR_W x DATA_W memory.
// Latency: req seen in IDLE -> ack next cycle; valid[g] seen -> valid_mem two cycles later.
// Backpressure: losers keep req asserted and wait; the owner holds the bus until valid, abort or timeout.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   req/valid/rw            per-processor request, transfer strobe, 1=load 0=store
//   address_m/data          packed per-processor address and store data (slice i = processor i)
//   ack/valid_mem           one-hot grant pulse / one-hot completion pulse
//   busy                    bus owned (any state but IDLE)
//   data_mem                load data during the completion cycle, otherwise 0
//   grant_id                index of the current or most recent owner
//   timeout_err             one-cycle pulse when the owner never drives valid
module mem_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        valid,
    input  logic [NUM_REQ-1:0]        rw,
    input  logic [NUM_REQ*ADDR_W-1:0] address_m,
    input  logic [NUM_REQ*DATA_W-1:0] data,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      busy,
    output logic [NUM_REQ-1:0]        valid_mem,
    output logic [DATA_W-1:0]         data_mem,
    output logic [ID_W-1:0]           grant_id,
    output logic                      timeout_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        GRANT      = 3'd1,
        WAIT_VALID = 3'd2,
        ACCESS     = 3'd3,
        RESP       = 3'd4
    } state_t;

    // One captured access from the owning processor.
    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dat;
    } acc_hdr_t;

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   pick;
    logic [ID_W-1:0]   idx;
    logic              pick_vld;
    logic [ID_W-1:0]   ptr_after_owner;
    logic [CNT_W-1:0]  wait_cnt;
    acc_hdr_t          cap;
    acc_hdr_t          slice_hdr;
    logic              own_vld;
    logic              own_req;
    logic              do_capture;
    logic              do_release;
    logic              do_timeout;
    logic [DATA_W-1:0] mem_rd;

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    // Rotating priority scan: first set req bit starting at ptr.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        idx      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (!pick_vld && req[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    assign own_vld         = valid[grant_id];
    assign own_req         = req[grant_id];
    assign slice_hdr.rw    = rw[grant_id];
    assign slice_hdr.addr  = address_m[int'(grant_id)*ADDR_W +: ADDR_W];
    assign slice_hdr.dat   = data[int'(grant_id)*DATA_W +: DATA_W];
    assign ptr_after_owner = (int'(grant_id) == NUM_REQ-1) ? '0 : grant_id + ID_W'(1);
    assign mem_rd          = mem[cap.addr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Valid beats abort, and abort beats timeout (an abandoned request needs no error).
    always_comb begin
        state_nxt  = state;
        do_capture = 1'b0;
        do_release = 1'b0;
        do_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                state_nxt = WAIT_VALID;
            end
            WAIT_VALID: begin
                if (own_vld) begin
                    state_nxt  = ACCESS;
                    do_capture = 1'b1;
                end else if (!own_req) begin
                    state_nxt  = IDLE;
                    do_release = 1'b1;
                end else if (wait_cnt == CNT_W'(TIMEOUT-1)) begin
                    state_nxt  = IDLE;
                    do_release = 1'b1;
                    do_timeout = 1'b1;
                end
            end
            ACCESS: begin
                state_nxt = RESP;
            end
            RESP: begin
                state_nxt  = IDLE;
                do_release = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr         <= '0;
            grant_id    <= '0;
            wait_cnt    <= '0;
            cap         <= '0;
            data_mem    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= do_timeout;
            if (state == IDLE && pick_vld) begin
                grant_id <= pick;
            end
            // Counts WAIT_VALID cycles already spent without valid from the owner.
            if (state == WAIT_VALID && state_nxt == WAIT_VALID) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (do_capture) begin
                cap <= slice_hdr;
            end
            if (do_release) begin
                ptr <= ptr_after_owner;
            end
            // Holds load data only through RESP; zero in every other cycle.
            data_mem <= (state == ACCESS && cap.rw) ? mem_rd : '0;
        end
    end

    // Storage is not reset; a reset that lands before ACCESS leaves it untouched.
    always_ff @(posedge clk) begin
        if (state == ACCESS && !cap.rw) begin
            mem[cap.addr] <= cap.dat;
        end
    end

    assign busy      = (state != IDLE);
    assign ack       = (state == GRANT) ? (NUM_REQ'(1) << grant_id) : '0;
    assign valid_mem = (state == RESP)  ? (NUM_REQ'(1) << grant_id) : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a transaction-level model.
module tb_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req, valid, rw;
    logic [N*AW-1:0] address_m;
    logic [N*DW-1:0] data;
    logic [N-1:0]   ack, valid_mem;
    logic           busy, timeout_err;
    logic [DW-1:0]  data_mem;
    logic [1:0]     grant_id;

    mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .valid(valid), .rw(rw),
        .address_m(address_m), .data(data), .ack(ack), .busy(busy),
        .valid_mem(valid_mem), .data_mem(data_mem), .grant_id(grant_id),
        .timeout_err(timeout_err)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_expired(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: cycle budget expired (t=%0t)", name, $time);
    endtask

    // ---------------- transaction-level reference model ----------------
    // A transaction is described by its owner, the cycle its ack appears and the
    // cycle its response appears; outputs follow from cycle offsets.
    int          m_own, m_ptr, m_gid, m_t_ack, m_t_resp, m_cyc;
    bit          m_pend_wr, m_is_load;
    int          m_pend_addr;
    logic [7:0]  m_pend_dat, m_load_val;
    logic [7:0]  m_mem [256];
    logic [N-1:0] e_ack, e_vm;
    logic [7:0]  e_dm;
    logic        e_to, e_busy;
    int          e_gid;

    function automatic void model_reset();
        m_own = -1; m_ptr = 0; m_gid = 0; m_t_ack = 0; m_t_resp = -1;
        m_pend_wr = 0; m_is_load = 0;
        e_ack = '0; e_vm = '0; e_dm = '0; e_to = 0; e_busy = 0; e_gid = 0;
    endfunction

    function automatic void model_finish();
        m_ptr = (m_own + 1) % N;
        m_own = -1;
    endfunction

    // Uses the inputs of the current cycle; yields expectations for the next one.
    function automatic void model_step();
        logic [N-1:0] n_ack, n_vm;
        logic [7:0]   n_dm;
        logic         n_to;
        int           c, a;
        if (reset_n !== 1'b1) begin
            model_reset();
            return;
        end
        c = m_cyc;
        m_cyc++;
        n_ack = '0; n_vm = '0; n_dm = '0; n_to = 0;
        if (m_own < 0) begin
            for (int k = 0; k < N; k++) begin
                int p;
                p = (m_ptr + k) % N;
                if (m_own < 0 && req[p]) m_own = p;
            end
            if (m_own >= 0) begin
                m_gid = m_own; m_t_ack = c + 1; m_t_resp = -1;
                n_ack[m_own] = 1'b1;
            end
        end else if (m_t_resp < 0) begin
            if (c > m_t_ack) begin
                if (valid[m_own]) begin
                    m_t_resp  = c + 2;
                    a         = int'(address_m[m_own*AW +: AW]);
                    m_is_load = rw[m_own];
                    if (rw[m_own]) m_load_val = m_mem[a];
                    else begin
                        m_pend_wr = 1; m_pend_addr = a; m_pend_dat = data[m_own*DW +: DW];
                    end
                end else if (!req[m_own]) begin
                    model_finish();
                end else if (c - m_t_ack == TO) begin
                    n_to = 1'b1;
                    model_finish();
                end
            end
        end else if (c + 1 == m_t_resp) begin
            if (m_pend_wr) m_mem[m_pend_addr] = m_pend_dat;
            m_pend_wr = 0;
            n_vm[m_own] = 1'b1;
            n_dm = m_is_load ? m_load_val : 8'h00;
        end else if (c == m_t_resp) begin
            model_finish();
        end
        e_ack = n_ack; e_vm = n_vm; e_dm = n_dm; e_to = n_to;
        e_busy = (m_own >= 0); e_gid = m_gid;
    endfunction

    // ---------------- compare process and observation logs ----------------
    int          cyc_obs = 0, last_ack_cyc = 0, to_gap = -1, vm_count = 0;
    logic        busy_at_to = 1'bx;
    logic [N-1:0] last_vm = '0;
    logic [7:0]  last_dm = '0;
    int          grant_log[$];

    always @(negedge clk) begin
        check("ack",         32'(ack),         32'(e_ack));
        check("busy",        32'(busy),        32'(e_busy));
        check("valid_mem",   32'(valid_mem),   32'(e_vm));
        check("data_mem",    32'(data_mem),    32'(e_dm));
        check("grant_id",    32'(grant_id),    e_gid);
        check("timeout_err", 32'(timeout_err), 32'(e_to));
        cyc_obs++;
        if (ack != '0) begin
            for (int k = 0; k < N; k++) if (ack[k]) grant_log.push_back(k);
            last_ack_cyc = cyc_obs;
        end
        if (timeout_err === 1'b1) begin
            to_gap = cyc_obs - last_ack_cyc;
            busy_at_to = busy;
        end
        if (valid_mem != '0) begin
            vm_count++;
            last_vm = valid_mem;
            last_dm = data_mem;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_grant(input int p);
        int b = 0;
        while (e_ack[p] !== 1'b1 && b < 64) begin step(); b++; end
        if (b >= 64) bound_expired($sformatf("wait_grant_p%0d", p));
    endtask

    task automatic wait_idle();
        int b = 0;
        while (m_own >= 0 && b < 64) begin step(); b++; end
        if (b >= 64) bound_expired("wait_idle");
    endtask

    task automatic do_txn(input int p, input bit ld, input int a, input int d, input int vdelay);
        req[p] = 1'b1;
        wait_grant(p);
        step();
        repeat (vdelay) step();
        valid[p] = 1'b1; rw[p] = ld;
        address_m[p*AW +: AW] = AW'(a);
        data[p*DW +: DW]      = DW'(d);
        step();
        valid[p] = 1'b0; req[p] = 1'b0;
        wait_idle();
    endtask

    // Answers each grant with a load of the owner's own index; drops all req after the last.
    task automatic serve(input int n);
        for (int i = 0; i < n; i++) begin
            int b = 0;
            int p = 0;
            while (e_ack == '0 && b < 64) begin step(); b++; end
            if (b >= 64) bound_expired("serve_grant");
            for (int k = 0; k < N; k++) if (e_ack[k]) p = k;
            step();
            valid[p] = 1'b1; rw[p] = 1'b1; address_m[p*AW +: AW] = AW'(p);
            step();
            valid[p] = 1'b0;
            if (i == n - 1) req = '0;
            wait_idle();
        end
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        repeat (cycles) step();
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vm_before;
        reset_n = 1'b0; req = '0; valid = '0; rw = '0; address_m = '0; data = '0;
        m_cyc = 0;
        model_reset();
        step();
        check("rst_busy", 32'(busy), 0);
        check("rst_ack",  32'(ack),  0);
        check("rst_gid",  32'(grant_id), 0);
        step();
        reset_n = 1'b1;

        // Known contents for addresses 0..15: value = a*7+3.
        for (int a = 0; a < 16; a++) do_txn(0, 1'b0, a, (a*7+3) & 8'hFF, a % 3);

        // Single store then load by P1.
        grant_log.delete();
        do_txn(1, 1'b0, 8'h10, 8'h5A, 2);
        do_txn(1, 1'b1, 8'h10, 0, 0);
        check("p1_ack_count", 32'(grant_log.size()), 2);
        check("p1_load_vm",   32'(last_vm), 32'h2);
        check("p1_load_dm",   32'(last_dm), 32'h5A);

        // Round robin from reset with everyone requesting.
        do_reset(2);
        grant_log.delete();
        req = 4'b1111;
        serve(5);
        check("rr_count", 32'(grant_log.size()), 5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            check($sformatf("rr_grant%0d", i), 32'(grant_log[i]), 32'(i % 4));

        // Wrap and skip: P2 leaves ptr at 3, then 0101 must give P0 then P2.
        do_txn(2, 1'b1, 2, 0, 0);
        grant_log.delete();
        req = 4'b0101;
        serve(2);
        check("wrap_count", 32'(grant_log.size()), 2);
        if (grant_log.size() == 2) begin
            check("wrap_first",  32'(grant_log[0]), 0);
            check("wrap_second", 32'(grant_log[1]), 2);
        end

        // Timeout: P2 never drives valid; P3 joins while busy and must win next.
        grant_log.delete();
        to_gap = -1;
        req = 4'b0100;
        wait_grant(2);
        req = 4'b1100;
        wait_idle();
        step();
        req[2] = 1'b0;
        do_txn(3, 1'b1, 3, 0, 0);
        // GRANT cycle, 16 WAIT_VALID cycles, then the pulse cycle.
        check("to_gap",       32'(to_gap), 17);
        check("to_busy",      32'(busy_at_to), 0);
        check("to_next_cnt",  32'(grant_log.size()), 2);
        if (grant_log.size() == 2) check("to_next_grant", 32'(grant_log[1]), 3);

        // Abort: P0 drops req with a store pending on its bus but never valid.
        vm_before = vm_count;
        req = 4'b0001;
        wait_grant(0);
        step();
        rw[0] = 1'b0; address_m[0 +: AW] = 8'd5; data[0 +: DW] = 8'hCC; req[0] = 1'b0;
        step();
        wait_idle();
        check("abort_no_vm", 32'(vm_count), 32'(vm_before));
        do_txn(0, 1'b1, 5, 0, 1);
        check("abort_old_val", 32'(last_dm), 32'h26);

        // Reset while P1 sits in WAIT_VALID with a store staged.
        req = 4'b0010;
        wait_grant(1);
        step();
        rw[1] = 1'b0; address_m[AW +: AW] = 8'd6; data[DW +: DW] = 8'hEE;
        step();
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_gid",  32'(grant_id), 0);
        req = '0;
        repeat (2) step();
        reset_n = 1'b1;
        do_txn(1, 1'b1, 6, 0, 0);
        check("midrst_old_val", 32'(last_dm), 32'h2D);
        check("midrst_vm",      32'(last_vm), 32'h2);

        // Randomized traffic with occasional quiet windows and reset pulses.
        for (int i = 0; i < 4000; i++) begin
            reset_n = 1'b1;
            for (int k = 0; k < N; k++) begin
                if (req[k]) begin
                    if ($urandom_range(0, 15) == 0) req[k] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req[k] = 1'b1;
                end
                valid[k] = ((i % 300) >= 40) && ($urandom_range(0, 3) == 0);
                rw[k]    = 1'($urandom_range(0, 1));
                address_m[k*AW +: AW] = AW'($urandom_range(0, 16));
                data[k*DW +: DW]      = DW'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 499) == 0) reset_n = 1'b0;
            step();
        end
        reset_n = 1'b1; req = '0; valid = '0;
        wait_idle();
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters (name, default, meaning): NUM_REQ, 4, number of processor requesters; ADDR_W, 8, address width; DATA_W, 8, data width; TIMEOUT, 16, maximum WAIT_VALID cycles.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  NUM_REQ  per-processor bus request, level.
REQ-005 valid  input  NUM_REQ  per-processor "address, rw and data are valid this cycle".
REQ-006 rw  input  NUM_REQ  per-processor access type: 1 = load (read), 0 = store (write).
REQ-007 address_m  input  NUM_REQ*ADDR_W  packed addresses; processor i occupies bits [i*ADDR_W +: ADDR_W].
REQ-008 data  input  NUM_REQ*DATA_W  packed store data; processor i occupies bits [i*DATA_W +: DATA_W].
REQ-009 ack  output  NUM_REQ  one-hot grant pulse.
REQ-010 busy  output  1  bus owned; high in every state except IDLE.
REQ-011 valid_mem  output  NUM_REQ  one-hot completion pulse to the granted processor.
REQ-012 data_mem  output  DATA_W  load data; 0 for stores and when idle.
REQ-013 grant_id  output  log2(NUM_REQ)  index of the current or last owner.
REQ-014 timeout_err  output  1  one-cycle pulse on a grant timeout.

Function
REQ-015 The block SHALL contain a 2^ADDR_W x DATA_W memory array; its contents are not reset.
REQ-016 FSM states SHALL be IDLE, GRANT, WAIT_VALID, ACCESS and RESP; all outputs SHALL be registered or decoded from state only.
REQ-017 In IDLE with req != 0, the FSM SHALL select g, the first set req bit scanning ptr, ptr+1, ... mod NUM_REQ. It SHALL latch g into grant_id and move to GRANT.
REQ-018 In GRANT (exactly 1 cycle), ack[g] SHALL be 1 and all other ack bits 0; the next state is WAIT_VALID.
REQ-019 In WAIT_VALID, valid[g]=1 SHALL capture address, rw and data of slice g and move to ACCESS.
REQ-020 In WAIT_VALID, valid bits of non-granted processors SHALL be ignored.
REQ-021 In WAIT_VALID, if req[g]=0 and valid[g]=0, the FSM SHALL abort to IDLE with no memory access and no pulse.
REQ-022 In WAIT_VALID, if TIMEOUT consecutive cycles pass without valid[g], the FSM SHALL pulse timeout_err for 1 cycle and return to IDLE.
REQ-023 Valid takes priority over timeout and abort when they occur in the same cycle.
REQ-024 In ACCESS (1 cycle), a store SHALL write mem[addr] <= data; a load SHALL register mem[addr] into data_mem.
REQ-025 In RESP (1 cycle), valid_mem[g] SHALL be 1; data_mem SHALL hold load data (0 for a store); the next state is IDLE.
REQ-026 In all other cycles data_mem SHALL be 0.
REQ-027 On leaving WAIT_VALID or RESP toward IDLE (completion, abort or timeout), ptr SHALL become (g+1) mod NUM_REQ, wrapping NUM_REQ-1 to 0.
REQ-028 Latency: with req[g] sampled in IDLE at edge k, ack is high in cycle k+1. With valid[g] sampled at edge m, valid_mem is high in cycle m+2.
REQ-029 A request arriving while busy=1 SHALL wait; req is never dropped by the arbiter.
REQ-030 A store followed by a load to the same address SHALL return the stored value.

Reset
REQ-031 While reset_n=0, the block SHALL asynchronously force state=IDLE, ptr=0, grant_id=0, timeout counter=0, and ack, valid_mem, busy, data_mem, timeout_err all 0.
REQ-032 Reset asserted mid-transaction SHALL cancel the transaction: a store not yet in ACCESS SHALL NOT write memory, and no valid_mem pulse SHALL follow release.
REQ-033 After reset_n rises, the first arbitration SHALL start from processor 0.

Verification
REQ-034 Single store/load: P1 stores 0x5A to 0x10, then loads 0x10 -> ack[1] pulses each time; load RESP gives valid_mem[1]=1 and data_mem=0x5A.
REQ-035 Round-robin: req=4'b1111 held after reset -> grant order 0,1,2,3,0 with one ack per transaction; no processor is granted twice while others wait.
REQ-036 Wrap and skip: ptr=3 and req=4'b0101 -> grant P0, then P2.
REQ-037 Timeout: P2 granted, valid[2] never asserted, req held -> timeout_err pulses 16 cycles after GRANT; busy falls; the next grant scans from P3.
REQ-038 Abort: P0 granted, then drops req before valid -> IDLE with no valid_mem and no memory change; a later read of that address returns its old value.
REQ-039 Reset mid-store: reset_n pulsed low while in WAIT_VALID -> all outputs 0 immediately; a later read of the target address returns the pre-store value.
